// File: rtl/pattern_phase_driver.sv
// pattern_phase_driver: pattern buffer store that replays buffers onto P/N drivers after dead-time on each pwm edge
module pattern_phase_driver #(
    parameter int WIDTH = 8,
    parameter int NO_TWEAKS = 8,
    parameter int NO_BUFS = 8,
    parameter int DEADTIME = 2,
    localparam int FIELDS = 2 + 2 * (2 + NO_TWEAKS),
    localparam int BUFP_W = NO_BUFS > 1 ? $clog2(NO_BUFS) : 1,
    localparam int FIELDP_W = $clog2(FIELDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pwm,
    input  logic                          drive_en,
    input  logic [BUFP_W-1:0]             bufp_in,
    input  logic [FIELDP_W-1:0]           fieldp_in,
    input  logic [FIELDP_W-1:0]           fieldwp_in,
    input  logic [WIDTH-1:0]              field_in_in,
    input  logic                          field_write_in,
    output logic [WIDTH-1:0]              field_byte_out,
    output logic [WIDTH-1:0]              p_drive,
    output logic [WIDTH-1:0]              n_drive,
    output logic [WIDTH-1:0]              tweak_sense,
    output logic [WIDTH-1:0]              tweak_delay,
    output logic [NO_TWEAKS*WIDTH-1:0]    tweak_drive,
    output logic                          dead_active
);
    localparam logic [BUFP_W:0] NB = (BUFP_W + 1)'(NO_BUFS);
    localparam logic [BUFP_W-1:0] LAST = BUFP_W'(NO_BUFS - 1);
    localparam logic [FIELDP_W:0] NF = (FIELDP_W + 1)'(FIELDS);
    localparam logic [7:0] DT = 8'(DEADTIME);
    localparam int PN = 4 + NO_TWEAKS;
    logic [WIDTH-1:0] store [NO_BUFS][FIELDS];
    logic pwm_prev;
    logic [BUFP_W-1:0] buf_sel;
    logic [7:0] dead_cnt;
    logic pwm_edge, off, wr_ok, rd_ok;
    logic [WIDTH-1:0] p_nx, n_nx, s_nx, d_nx;
    logic [NO_TWEAKS*WIDTH-1:0] t_nx;
    assign pwm_edge = pwm != pwm_prev;
    assign off = !drive_en || dead_cnt != 8'd0;
    assign wr_ok = field_write_in && {1'b0, bufp_in} < NB && {1'b0, fieldwp_in} < NF;
    assign rd_ok = {1'b0, bufp_in} < NB && {1'b0, fieldp_in} < NF;
    // drive values come from the pre-edge phase and selection
    always_comb begin
        t_nx = '0;
        p_nx = off || !pwm_prev ? '1 : store[buf_sel][0];
        n_nx = off || pwm_prev ? '0 : store[buf_sel][1];
        s_nx = off ? '0 : pwm_prev ? store[buf_sel][2] : store[buf_sel][PN];
        d_nx = off ? '0 : pwm_prev ? store[buf_sel][3] : store[buf_sel][PN+1];
        for (int k = 0; k < NO_TWEAKS; k++)
            t_nx[k*WIDTH +: WIDTH] = off ? '0 : pwm_prev ? store[buf_sel][4+k] : store[buf_sel][PN+2+k];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NO_BUFS; b++)
                for (int f = 0; f < FIELDS; f++)
                    store[b][f] <= '0;
            pwm_prev <= 1'b0;
            buf_sel <= '0;
            dead_cnt <= '0;
            field_byte_out <= '0;
            p_drive <= '1;
            n_drive <= '0;
            tweak_sense <= '0;
            tweak_delay <= '0;
            tweak_drive <= '0;
            dead_active <= 1'b0;
        end else begin
            if (wr_ok)
                store[bufp_in][fieldwp_in] <= field_in_in;
            field_byte_out <= rd_ok ? store[bufp_in][fieldp_in] : '0;
            if (pwm_edge) begin
                pwm_prev <= pwm;
                buf_sel <= '0;
                dead_cnt <= DT;
            end else if (dead_cnt != 8'd0) begin
                dead_cnt <= dead_cnt - 8'd1;
                buf_sel <= '0;
            end else if (buf_sel != LAST) begin
                buf_sel <= buf_sel + 1'b1;
            end
            p_drive <= p_nx;
            n_drive <= n_nx;
            tweak_sense <= s_nx;
            tweak_delay <= d_nx;
            tweak_drive <= t_nx;
            dead_active <= dead_cnt != 8'd0;
        end
    end
endmodule

// File: tb/tb_pattern_phase_driver.sv
// tb_pattern_phase_driver: randomized and directed stimulus checked against a cycle-age reference model
module tb_pattern_phase_driver;
    localparam int W = 8, NT = 8, NB = 8, DT = 2;
    localparam int F = 2 + 2 * (2 + NT), BW = 3, FW = 5;
    logic clk = 1'b0;
    logic rst = 1'b1, pwm = 1'b0, drive_en = 1'b1, field_write_in = 1'b0;
    logic [BW-1:0] bufp_in = '0;
    logic [FW-1:0] fieldp_in = '0, fieldwp_in = '0;
    logic [W-1:0] field_in_in = '0;
    logic [W-1:0] field_byte_out, p_drive, n_drive, tweak_sense, tweak_delay;
    logic [NT*W-1:0] tweak_drive;
    logic dead_active;
    int checks = 0, failures = 0;
    logic [W-1:0] mem [NB][F];
    logic m_prev = 1'b0;
    int m_age = DT + 1;

    pattern_phase_driver #(.WIDTH(W), .NO_TWEAKS(NT), .NO_BUFS(NB), .DEADTIME(DT)) dut (
        .clk(clk), .rst(rst), .pwm(pwm), .drive_en(drive_en),
        .bufp_in(bufp_in), .fieldp_in(fieldp_in), .fieldwp_in(fieldwp_in),
        .field_in_in(field_in_in), .field_write_in(field_write_in),
        .field_byte_out(field_byte_out), .p_drive(p_drive), .n_drive(n_drive),
        .tweak_sense(tweak_sense), .tweak_delay(tweak_delay),
        .tweak_drive(tweak_drive), .dead_active(dead_active));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NT*W-1:0] got, input logic [NT*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs are derived from the age of the last pwm change, not from any counter.
    task automatic step();
        logic [W-1:0] e_rd, e_p, e_n, e_s, e_d;
        logic [NT*W-1:0] e_t;
        logic e_dead;
        int bi;
        e_rd = '0; e_p = '1; e_n = '0; e_s = '0; e_d = '0; e_t = '0; e_dead = 1'b0;
        if (!rst) begin
            if (int'(bufp_in) < NB && int'(fieldp_in) < F) e_rd = mem[bufp_in][fieldp_in];
            bi = m_age - DT - 1;
            if (bi < 0) bi = 0;
            if (bi > NB - 1) bi = NB - 1;
            e_dead = m_age <= DT;
            if (drive_en && !e_dead) begin
                if (m_prev) begin
                    e_p = mem[bi][0]; e_s = mem[bi][2]; e_d = mem[bi][3];
                    for (int k = 0; k < NT; k++) e_t[k*W +: W] = mem[bi][4+k];
                end else begin
                    e_n = mem[bi][1]; e_s = mem[bi][4+NT]; e_d = mem[bi][5+NT];
                    for (int k = 0; k < NT; k++) e_t[k*W +: W] = mem[bi][6+NT+k];
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int b = 0; b < NB; b++) for (int f = 0; f < F; f++) mem[b][f] = '0;
            m_prev = 1'b0;
            m_age = DT + 1;
        end else begin
            if (field_write_in && int'(bufp_in) < NB && int'(fieldwp_in) < F) mem[bufp_in][fieldwp_in] = field_in_in;
            if (pwm != m_prev) begin
                m_prev = pwm;
                m_age = 1;
            end else if (m_age < 100000) m_age++;
        end
        #1;
        check("rd", {56'd0, field_byte_out}, {56'd0, e_rd});
        check("p_drive", {56'd0, p_drive}, {56'd0, e_p});
        check("n_drive", {56'd0, n_drive}, {56'd0, e_n});
        check("sense", {56'd0, tweak_sense}, {56'd0, e_s});
        check("delay", {56'd0, tweak_delay}, {56'd0, e_d});
        check("tweaks", tweak_drive, e_t);
        check("dead", {63'd0, dead_active}, {63'd0, e_dead});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        steps(2);
        rst = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int f = 0; f < F; f++) begin
                bufp_in = BW'(b); fieldp_in = FW'(f); step();
            end
        field_write_in = 1'b1;
        for (int b = 0; b < NB; b++)
            for (int f = 0; f < F; f++) begin
                bufp_in = BW'(b); fieldwp_in = FW'(f); fieldp_in = FW'(f);
                field_in_in = W'(b * 32 + f); step();
            end
        for (int f = F; f < 32; f++) begin
            bufp_in = BW'(f % NB); fieldwp_in = FW'(f); fieldp_in = FW'(f);
            field_in_in = 8'hEE; step();
        end
        field_write_in = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int f = 0; f < F; f++) begin
                bufp_in = BW'(b); fieldp_in = FW'(f); step();
            end
        bufp_in = 3'd3; fieldp_in = 5'd5; fieldwp_in = 5'd5; field_in_in = 8'h5A;
        field_write_in = 1'b1; step();
        field_write_in = 1'b0; step();
        pwm = 1'b1; steps(14);
        pwm = 1'b0; steps(14);
        pwm = 1'b1; step();
        pwm = 1'b0; steps(12);
        pwm = 1'b1; steps(5);
        drive_en = 1'b0; steps(2);
        drive_en = 1'b1; steps(6);
        rst = 1'b1; step();
        rst = 1'b0; steps(4);
        for (int i = 0; i < 800; i++) begin
            rst = $urandom_range(99) == 0;
            if ($urandom_range(11) == 0) pwm = ~pwm;
            drive_en = $urandom_range(9) != 0;
            field_write_in = $urandom_range(2) == 0;
            bufp_in = BW'($urandom);
            fieldp_in = FW'($urandom);
            fieldwp_in = $urandom_range(3) == 0 ? fieldp_in : FW'($urandom);
            field_in_in = W'($urandom);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
